// File: rtl/mem_stage_hs_if.sv
// Handshake and data-memory bus bundle for the memory pipeline stage.
// The stage itself connects through the slave modport; whatever drives the
// instruction stream and models the memory uses the master modport.
interface mem_stage_hs_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5,
  parameter int WB_W   = 2
);
  // upstream instruction
  logic                  in_valid;
  logic                  in_ready;
  logic [WB_W-1:0]       wb_in;
  logic                  mem_read;
  logic                  mem_write;
  logic                  branch_in;
  logic [1:0]            size;
  logic                  uns;
  logic                  zero;
  logic [DATA_W-1:0]     result;
  logic [DATA_W-1:0]     write_data;
  logic [REG_W-1:0]      write_reg;

  // data memory
  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic [DATA_W/8-1:0]   dm_be;
  logic                  dm_ack;
  logic [DATA_W-1:0]     dm_rdata;

  // retire
  logic                  out_valid;
  logic [WB_W-1:0]       wb_out;
  logic [DATA_W-1:0]     read_data;
  logic [DATA_W-1:0]     result_out;
  logic [REG_W-1:0]      write_reg_out;
  logic                  branch_taken;
  logic                  misalign_err;
  logic                  bus_err;

  modport slave (
    input  in_valid, wb_in, mem_read, mem_write, branch_in, size, uns, zero,
           result, write_data, write_reg, dm_ack, dm_rdata,
    output in_ready, dm_req, dm_we, dm_addr, dm_wdata, dm_be,
           out_valid, wb_out, read_data, result_out, write_reg_out,
           branch_taken, misalign_err, bus_err
  );

  modport master (
    output in_valid, wb_in, mem_read, mem_write, branch_in, size, uns, zero,
           result, write_data, write_reg, dm_ack, dm_rdata,
    input  in_ready, dm_req, dm_we, dm_addr, dm_wdata, dm_be,
           out_valid, wb_out, read_data, result_out, write_reg_out,
           branch_taken, misalign_err, bus_err
  );
endinterface

// File: rtl/mem_stage_hs.sv
// Memory pipeline stage with valid/ready upstream handshake and a req/ack
// data-memory port. Non-memory ops retire one edge after acceptance; memory
// ops hold a registered request until ack or until the wait budget expires.
// The interface instance must be built with the same widths as this module.
//
// state  | meaning
// IDLE   | ready for a new instruction; ALU and misaligned ops retire from here
// ACCESS | request outstanding on the data-memory port, waiting for dm_ack
module mem_stage_hs #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int REG_W   = 5,
  parameter int WB_W    = 2,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  mem_stage_hs_if.slave   bus
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t state, state_nx;

  logic              is_mem;
  logic              aligned;
  logic [2:0]        in_off;
  logic [NB-1:0]     be_base;
  logic [NB-1:0]     in_be;
  logic [DATA_W-1:0] in_wdata;

  logic              go_alu, go_mis, go_mem, done_ok, done_to;
  logic [7:0]        cnt;

  logic [WB_W-1:0]   q_wb;
  logic              q_we;
  logic [1:0]        q_size;
  logic              q_uns;
  logic [2:0]        q_off;
  logic [DATA_W-1:0] q_result;
  logic [REG_W-1:0]  q_reg;
  logic              q_branch;

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] load_data;

  assign is_mem      = bus.mem_read | bus.mem_write;
  assign in_off      = 3'(bus.result[OFF_W-1:0]);
  assign bus.in_ready = (state == IDLE);

  // alignment of the incoming access; dword only exists on a 64-bit datapath
  always_comb begin
    aligned = 1'b0;
    case (bus.size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~in_off[0];
      2'b10:   aligned = (in_off[1:0] == 2'b00);
      default: aligned = (DATA_W == 64) && (in_off == 3'b000);
    endcase
  end

  // byte enables and lane-replicated store data for the incoming access
  always_comb begin
    be_base  = '1;
    in_wdata = bus.write_data;
    case (bus.size)
      2'b00: begin
        be_base  = NB'(1);
        in_wdata = {NB{bus.write_data[7:0]}};
      end
      2'b01: begin
        be_base  = NB'(3);
        in_wdata = {(NB/2){bus.write_data[15:0]}};
      end
      2'b10: begin
        be_base  = NB'(15);
        in_wdata = {(NB/4){bus.write_data[31:0]}};
      end
      default: begin
        be_base  = '1;
        in_wdata = bus.write_data;
      end
    endcase
    in_be = be_base << in_off;
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // next state and per-cycle actions; ack beats an expiring wait counter
  always_comb begin
    state_nx = state;
    go_alu   = 1'b0;
    go_mis   = 1'b0;
    go_mem   = 1'b0;
    done_ok  = 1'b0;
    done_to  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (!is_mem) begin
            go_alu = 1'b1;
          end else if (!aligned) begin
            go_mis = 1'b1;
          end else begin
            go_mem   = 1'b1;
            state_nx = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (bus.dm_ack) begin
          done_ok  = 1'b1;
          state_nx = IDLE;
        end else if (cnt == TO_LAST) begin
          done_to  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // wait counter: counts ACCESS cycles that passed without an ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state == ACCESS && !done_ok && !done_to) begin
      cnt <= cnt + 8'd1;
    end else begin
      cnt <= '0;
    end
  end

  // lane extraction and extension of the returned load word
  always_comb begin
    shifted   = bus.dm_rdata >> {q_off, 3'b000};
    load_data = shifted;
    case (q_size)
      2'b00: begin
        if (q_uns) load_data = DATA_W'(shifted[7:0]);
        else       load_data = DATA_W'($signed(shifted[7:0]));
      end
      2'b01: begin
        if (q_uns) load_data = DATA_W'(shifted[15:0]);
        else       load_data = DATA_W'($signed(shifted[15:0]));
      end
      2'b10: begin
        if (q_uns) load_data = DATA_W'(shifted[31:0]);
        else       load_data = DATA_W'($signed(shifted[31:0]));
      end
      default: load_data = shifted;
    endcase
  end

  // captured instruction, memory port registers and retire outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_wb              <= '0;
      q_we              <= 1'b0;
      q_size            <= '0;
      q_uns             <= 1'b0;
      q_off             <= '0;
      q_result          <= '0;
      q_reg             <= '0;
      q_branch          <= 1'b0;
      bus.dm_req        <= 1'b0;
      bus.dm_we         <= 1'b0;
      bus.dm_addr       <= '0;
      bus.dm_wdata      <= '0;
      bus.dm_be         <= '0;
      bus.out_valid     <= 1'b0;
      bus.wb_out        <= '0;
      bus.read_data     <= '0;
      bus.result_out    <= '0;
      bus.write_reg_out <= '0;
      bus.branch_taken  <= 1'b0;
      bus.misalign_err  <= 1'b0;
      bus.bus_err       <= 1'b0;
    end else begin
      // flags only live for the single retire cycle
      bus.out_valid    <= 1'b0;
      bus.branch_taken <= 1'b0;
      bus.misalign_err <= 1'b0;
      bus.bus_err      <= 1'b0;

      if (go_alu) begin
        bus.out_valid     <= 1'b1;
        bus.wb_out        <= bus.wb_in;
        bus.result_out    <= bus.result;
        bus.write_reg_out <= bus.write_reg;
        bus.branch_taken  <= bus.branch_in & bus.zero;
        bus.read_data     <= '0;
      end

      if (go_mis) begin
        bus.out_valid     <= 1'b1;
        bus.misalign_err  <= 1'b1;
        bus.wb_out        <= '0;
        bus.result_out    <= bus.result;
        bus.write_reg_out <= bus.write_reg;
        bus.branch_taken  <= bus.branch_in & bus.zero;
        bus.read_data     <= '0;
      end

      if (go_mem) begin
        q_wb         <= bus.wb_in;
        q_we         <= bus.mem_write;
        q_size       <= bus.size;
        q_uns        <= bus.uns;
        q_off        <= in_off;
        q_result     <= bus.result;
        q_reg        <= bus.write_reg;
        q_branch     <= bus.branch_in & bus.zero;
        bus.dm_req   <= 1'b1;
        bus.dm_we    <= bus.mem_write;
        bus.dm_addr  <= ADDR_W'(bus.result);
        bus.dm_be    <= in_be;
        bus.dm_wdata <= in_wdata;
      end

      if (done_ok) begin
        bus.dm_req        <= 1'b0;
        bus.dm_we         <= 1'b0;
        bus.out_valid     <= 1'b1;
        bus.wb_out        <= q_wb;
        bus.result_out    <= q_result;
        bus.write_reg_out <= q_reg;
        bus.branch_taken  <= q_branch;
        bus.read_data     <= q_we ? '0 : load_data;
      end

      if (done_to) begin
        bus.dm_req        <= 1'b0;
        bus.dm_we         <= 1'b0;
        bus.out_valid     <= 1'b1;
        bus.bus_err       <= 1'b1;
        bus.wb_out        <= '0;
        bus.result_out    <= q_result;
        bus.write_reg_out <= q_reg;
        bus.branch_taken  <= q_branch;
        bus.read_data     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs, built with TIMEOUT=4 so the wait budget
// and the ack-at-expiry corner are reachable in a few cycles.
module tb_mem_stage_hs;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mem_stage_hs_if #(.DATA_W(32), .ADDR_W(32), .REG_W(5), .WB_W(2)) bus ();

  mem_stage_hs #(
    .DATA_W(32), .ADDR_W(32), .REG_W(5), .WB_W(2), .TIMEOUT(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.in_valid   = 1'b0;
    bus.wb_in      = 2'b00;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.branch_in  = 1'b0;
    bus.size       = 2'b00;
    bus.uns        = 1'b0;
    bus.zero       = 1'b0;
    bus.result     = 32'h0;
    bus.write_data = 32'h0;
    bus.write_reg  = 5'd0;
    bus.dm_ack     = 1'b0;
    bus.dm_rdata   = 32'h0;
  endtask

  // present one instruction for one edge, then withdraw it
  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic u, input logic [31:0] res,
                       input logic [31:0] wd, input logic [1:0] wb,
                       input logic [4:0] wreg, input logic br, input logic z);
    bus.in_valid   = 1'b1;
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.size       = sz;
    bus.uns        = u;
    bus.result     = res;
    bus.write_data = wd;
    bus.wb_in      = wb;
    bus.write_reg  = wreg;
    bus.branch_in  = br;
    bus.zero       = z;
    tick();
    bus.in_valid   = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    idle_inputs();
    tick();
    tick();
    tests++;
    if ({bus.dm_req, bus.dm_we, bus.dm_be, bus.out_valid, bus.misalign_err,
         bus.bus_err, bus.branch_taken} !== 10'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got req=%b we=%b be=%b ov=%b me=%b be=%b bt=%b, expected all 0",
               bus.dm_req, bus.dm_we, bus.dm_be, bus.out_valid, bus.misalign_err,
               bus.bus_err, bus.branch_taken);
    end
    tests++;
    if ({bus.dm_addr, bus.dm_wdata, bus.read_data, bus.result_out} !== 128'b0) begin
      fails++;
      $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h res=%h, expected 0",
               bus.dm_addr, bus.dm_wdata, bus.read_data, bus.result_out);
    end
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b expected 1", bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_alu;
    issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h1234, 32'h0, 2'b10, 5'd7, 1'b1, 1'b1);
    tests++;
    if ({bus.out_valid, bus.wb_out, bus.write_reg_out, bus.branch_taken} !== {1'b1, 2'b10, 5'd7, 1'b1}) begin
      fails++;
      $display("FAIL alu_retire: got ov=%b wb=%b reg=%0d bt=%b, expected ov=1 wb=10 reg=7 bt=1",
               bus.out_valid, bus.wb_out, bus.write_reg_out, bus.branch_taken);
    end
    tests++;
    if ({bus.result_out, bus.read_data} !== {32'h1234, 32'h0}) begin
      fails++;
      $display("FAIL alu_data: got res=%h rdata=%h, expected 00001234 00000000",
               bus.result_out, bus.read_data);
    end
    tests++;
    if (bus.dm_req !== 1'b0) begin
      fails++;
      $display("FAIL alu_no_req: got %b expected 0", bus.dm_req);
    end
    tick();
    tests++;
    if ({bus.out_valid, bus.branch_taken} !== 2'b00) begin
      fails++;
      $display("FAIL alu_pulse: got ov=%b bt=%b, expected 0 0", bus.out_valid, bus.branch_taken);
    end
  endtask

  task automatic test_load_byte;
    logic [31:0] exp_rd [2];
    exp_rd[0] = 32'hFFFF_FF80;
    exp_rd[1] = 32'h0000_0080;
    for (int u = 0; u < 2; u++) begin
      issue(1'b1, 1'b0, 2'b00, u[0], 32'h103, 32'h0, 2'b01, 5'd3, 1'b0, 1'b0);
      tests++;
      if ({bus.dm_req, bus.dm_we, bus.dm_be, bus.in_ready} !== {1'b1, 1'b0, 4'b1000, 1'b0}) begin
        fails++;
        $display("FAIL lb_req[%0d]: got req=%b we=%b be=%b rdy=%b, expected 1 0 1000 0",
                 u, bus.dm_req, bus.dm_we, bus.dm_be, bus.in_ready);
      end
      tests++;
      if (bus.dm_addr !== 32'h103) begin
        fails++;
        $display("FAIL lb_addr[%0d]: got %h expected 00000103", u, bus.dm_addr);
      end
      tick();
      tick();
      bus.dm_ack   = 1'b1;
      bus.dm_rdata = 32'h80FF_FFFF;
      tick();
      bus.dm_ack   = 1'b0;
      tests++;
      if ({bus.out_valid, bus.dm_req, bus.wb_out, bus.bus_err} !== {1'b1, 1'b0, 2'b01, 1'b0}) begin
        fails++;
        $display("FAIL lb_retire[%0d]: got ov=%b req=%b wb=%b be=%b, expected 1 0 01 0",
                 u, bus.out_valid, bus.dm_req, bus.wb_out, bus.bus_err);
      end
      tests++;
      if (bus.read_data !== exp_rd[u]) begin
        fails++;
        $display("FAIL lb_data[%0d]: got %h expected %h", u, bus.read_data, exp_rd[u]);
      end
      tick();
    end
  endtask

  task automatic test_load_half;
    issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 2'b11, 5'd9, 1'b0, 1'b0);
    tests++;
    if (bus.dm_be !== 4'b1100) begin
      fails++;
      $display("FAIL lh_be: got %b expected 1100", bus.dm_be);
    end
    bus.dm_ack   = 1'b1;
    bus.dm_rdata = 32'h8001_1234;
    tick();
    bus.dm_ack   = 1'b0;
    tests++;
    if ({bus.out_valid, bus.read_data} !== {1'b1, 32'hFFFF_8001}) begin
      fails++;
      $display("FAIL lh_data: got ov=%b rdata=%h, expected 1 ffff8001", bus.out_valid, bus.read_data);
    end
    tick();
  endtask

  task automatic test_store_half;
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'hABCD, 2'b00, 5'd0, 1'b0, 1'b0);
    tests++;
    if ({bus.dm_req, bus.dm_we, bus.dm_be, bus.dm_wdata} !== {1'b1, 1'b1, 4'b1100, 32'hABCD_ABCD}) begin
      fails++;
      $display("FAIL sh_req: got req=%b we=%b be=%b wdata=%h, expected 1 1 1100 abcdabcd",
               bus.dm_req, bus.dm_we, bus.dm_be, bus.dm_wdata);
    end
    tick();
    tests++;
    if ({bus.dm_req, bus.dm_we, bus.dm_be, bus.dm_wdata, bus.out_valid} !== {1'b1, 1'b1, 4'b1100, 32'hABCD_ABCD, 1'b0}) begin
      fails++;
      $display("FAIL sh_hold: got req=%b we=%b be=%b wdata=%h ov=%b, expected 1 1 1100 abcdabcd 0",
               bus.dm_req, bus.dm_we, bus.dm_be, bus.dm_wdata, bus.out_valid);
    end
    bus.dm_ack   = 1'b1;
    bus.dm_rdata = 32'hFFFF_FFFF;
    tick();
    bus.dm_ack   = 1'b0;
    tests++;
    if ({bus.out_valid, bus.dm_req, bus.dm_we, bus.read_data} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL sh_retire: got ov=%b req=%b we=%b rdata=%h, expected 1 0 0 00000000",
               bus.out_valid, bus.dm_req, bus.dm_we, bus.read_data);
    end
    tick();
  endtask

  // byte store at offset 1 with both read and write set, then a word store
  task automatic test_store_lanes;
    issue(1'b1, 1'b1, 2'b00, 1'b0, 32'h301, 32'h1234_565A, 2'b00, 5'd0, 1'b0, 1'b0);
    tests++;
    if ({bus.dm_we, bus.dm_be, bus.dm_wdata} !== {1'b1, 4'b0010, 32'h5A5A_5A5A}) begin
      fails++;
      $display("FAIL sb_lanes: got we=%b be=%b wdata=%h, expected 1 0010 5a5a5a5a",
               bus.dm_we, bus.dm_be, bus.dm_wdata);
    end
    bus.dm_ack = 1'b1;
    tick();
    bus.dm_ack = 1'b0;
    tick();
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h304, 32'hDEAD_BEEF, 2'b00, 5'd0, 1'b0, 1'b0);
    tests++;
    if ({bus.dm_be, bus.dm_wdata} !== {4'b1111, 32'hDEAD_BEEF}) begin
      fails++;
      $display("FAIL sw_lanes: got be=%b wdata=%h, expected 1111 deadbeef", bus.dm_be, bus.dm_wdata);
    end
    bus.dm_ack = 1'b1;
    tick();
    bus.dm_ack = 1'b0;
    tick();
  endtask

  task automatic test_misalign;
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 2'b11, 5'd4, 1'b0, 1'b0);
    tests++;
    if ({bus.dm_req, bus.out_valid, bus.misalign_err, bus.wb_out, bus.read_data} !== {1'b0, 1'b1, 1'b1, 2'b00, 32'h0}) begin
      fails++;
      $display("FAIL mis_word: got req=%b ov=%b me=%b wb=%b rdata=%h, expected 0 1 1 00 0",
               bus.dm_req, bus.out_valid, bus.misalign_err, bus.wb_out, bus.read_data);
    end
    tick();
    tests++;
    if ({bus.misalign_err, bus.out_valid, bus.in_ready} !== 3'b001) begin
      fails++;
      $display("FAIL mis_clear: got me=%b ov=%b rdy=%b, expected 0 0 1",
               bus.misalign_err, bus.out_valid, bus.in_ready);
    end
    issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 2'b11, 5'd4, 1'b0, 1'b0);
    tests++;
    if ({bus.dm_req, bus.out_valid, bus.misalign_err} !== 3'b011) begin
      fails++;
      $display("FAIL mis_dword: got req=%b ov=%b me=%b, expected 0 1 1",
               bus.dm_req, bus.out_valid, bus.misalign_err);
    end
    tick();
  endtask

  task automatic test_timeout;
    int n;
    n = 0;
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 2'b10, 5'd5, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (!bus.dm_req) break;
      n++;
      tick();
    end
    tests++;
    if (n !== 4) begin
      fails++;
      $display("FAIL to_req_cycles: got %0d expected 4", n);
    end
    tests++;
    if ({bus.out_valid, bus.bus_err, bus.wb_out, bus.read_data, bus.misalign_err} !== {1'b1, 1'b1, 2'b00, 32'h0, 1'b0}) begin
      fails++;
      $display("FAIL to_retire: got ov=%b be=%b wb=%b rdata=%h me=%b, expected 1 1 00 0 0",
               bus.out_valid, bus.bus_err, bus.wb_out, bus.read_data, bus.misalign_err);
    end
    tick();
    tests++;
    if ({bus.bus_err, bus.in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL to_clear: got be=%b rdy=%b, expected 0 1", bus.bus_err, bus.in_ready);
    end
  endtask

  task automatic test_ack_at_expiry;
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 2'b01, 5'd6, 1'b0, 1'b0);
    tests++;
    if (bus.dm_be !== 4'b1111) begin
      fails++;
      $display("FAIL exp_be: got %b expected 1111", bus.dm_be);
    end
    tick();
    tick();
    tick();
    bus.dm_ack   = 1'b1;
    bus.dm_rdata = 32'h1234_5678;
    tick();
    bus.dm_ack   = 1'b0;
    tests++;
    if ({bus.out_valid, bus.bus_err, bus.wb_out, bus.read_data} !== {1'b1, 1'b0, 2'b01, 32'h1234_5678}) begin
      fails++;
      $display("FAIL exp_ack_wins: got ov=%b be=%b wb=%b rdata=%h, expected 1 0 01 12345678",
               bus.out_valid, bus.bus_err, bus.wb_out, bus.read_data);
    end
    tick();
  endtask

  task automatic test_idle_ack;
    bus.dm_ack = 1'b1;
    tick();
    tick();
    bus.dm_ack = 1'b0;
    tests++;
    if ({bus.out_valid, bus.dm_req, bus.in_ready} !== 3'b001) begin
      fails++;
      $display("FAIL idle_ack: got ov=%b req=%b rdy=%b, expected 0 0 1",
               bus.out_valid, bus.dm_req, bus.in_ready);
    end
  endtask

  task automatic test_reset_in_access;
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 2'b10, 5'd8, 1'b0, 1'b0);
    tick();
    tests++;
    if (bus.dm_req !== 1'b1) begin
      fails++;
      $display("FAIL rst_acc_pre: got req=%b expected 1", bus.dm_req);
    end
    rst = 1'b0;
    #1;
    tests++;
    if ({bus.dm_req, bus.out_valid, bus.in_ready, bus.dm_be} !== {1'b0, 1'b0, 1'b1, 4'b0000}) begin
      fails++;
      $display("FAIL rst_acc_async: got req=%b ov=%b rdy=%b be=%b, expected 0 0 1 0000",
               bus.dm_req, bus.out_valid, bus.in_ready, bus.dm_be);
    end
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    tests++;
    if ({bus.in_ready, bus.out_valid, bus.dm_req} !== 3'b100) begin
      fails++;
      $display("FAIL rst_acc_release: got rdy=%b ov=%b req=%b, expected 1 0 0",
               bus.in_ready, bus.out_valid, bus.dm_req);
    end
    issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h55AA, 32'h0, 2'b01, 5'd2, 1'b0, 1'b1);
    tests++;
    if ({bus.out_valid, bus.result_out, bus.write_reg_out, bus.branch_taken} !== {1'b1, 32'h55AA, 5'd2, 1'b0}) begin
      fails++;
      $display("FAIL rst_acc_new_op: got ov=%b res=%h reg=%0d bt=%b, expected 1 000055aa 2 0",
               bus.out_valid, bus.result_out, bus.write_reg_out, bus.branch_taken);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_byte();
    test_load_half();
    test_store_half();
    test_store_lanes();
    test_misalign();
    test_timeout();
    test_ack_at_expiry();
    test_idle_ack();
    test_reset_in_access();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
